// File: rtl/acc_xbar_pkg.sv
// Shared types and helpers for the crossbar-fed accumulator banks:
// FSM state, the (row, col) -> (bank, entry) mapping and saturating add.
package acc_xbar_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        ACCUM,
        FLUSH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic        clipped;
        logic [63:0] value;
    } sat_res_t;

    // Diagonal interleave: neighbouring columns of one row and neighbouring
    // rows of one column both land in different banks.
    function automatic int bank_of(input int row, input int col, input int bank_count);
        return (row + col) % bank_count;
    endfunction

    function automatic int entry_of(input int row, input int col, input int tile_size,
                                    input int bank_count);
        return row * (tile_size / bank_count) + col / bank_count;
    endfunction

    // Operands arrive sign-extended to 64 bits, so the sum never wraps
    // before it is clipped to the acc_w-bit signed range.
    function automatic sat_res_t sat_add(input logic signed [63:0] acc,
                                         input logic signed [63:0] prod,
                                         input int                 acc_w);
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_res_t           r;
        sum       = acc + prod;
        max_v     = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v     = -max_v - 64'sd1;
        r.clipped = 1'b0;
        r.value   = sum;
        if (sum > max_v) begin
            r.clipped = 1'b1;
            r.value   = max_v;
        end else if (sum < min_v) begin
            r.clipped = 1'b1;
            r.value   = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/accumulator_xbar_banks_bank.sv
// One accumulator bank: two-stage read-modify-write with write-to-read
// forwarding, plus a zero-write port (clear/drain) and a drain read port.
module acc_bank
    import acc_xbar_pkg::*;
#(
    parameter int DEPTH         = 512,
    parameter int AW            = 9,
    parameter int PRODUCT_WIDTH = 16,
    parameter int ACC_WIDTH     = 24
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            acc_en,
    input  logic [AW-1:0]                   acc_addr,
    input  logic signed [PRODUCT_WIDTH-1:0] acc_prod,
    input  logic                            wz_en,
    input  logic [AW-1:0]                   wz_addr,
    input  logic                            rd_en,
    input  logic [AW-1:0]                   rd_addr,
    output logic signed [ACC_WIDTH-1:0]     rd_data,
    output logic                            sat_hit,
    output logic                            busy
);

    logic signed [ACC_WIDTH-1:0]     mem [DEPTH];
    logic                            vld_p1;
    logic [AW-1:0]                   addr_p1;
    logic signed [PRODUCT_WIDTH-1:0] prod_p1;
    logic signed [ACC_WIDTH-1:0]     acc_p1;
    logic signed [ACC_WIDTH-1:0]     sum_p1;
    sat_res_t                        res;

    // Stage 2: add and saturate
    always_comb begin
        res     = sat_add(64'(acc_p1), 64'(prod_p1), ACC_WIDTH);
        sum_p1  = ACC_WIDTH'(res.value);
        sat_hit = vld_p1 && res.clipped;
    end

    assign busy = vld_p1;

    always_ff @(posedge clk) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= acc_en;
    end

    // Stage 1: read, taking the in-flight sum when it targets the same entry
    always_ff @(posedge clk) begin
        if (acc_en) begin
            addr_p1 <= acc_addr;
            prod_p1 <= acc_prod;
            acc_p1  <= (vld_p1 && addr_p1 == acc_addr) ? sum_p1 : mem[acc_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wz_en)       mem[wz_addr] <= '0;
        else if (vld_p1) mem[addr_p1] <= sum_p1;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/accumulator_xbar_banks.sv
// Sparse-CNN tile accumulator: per-bank lowest-lane arbitration of tagged
// products into banked saturating accumulators, then a row-major drain.
module accumulator_xbar_banks
    import acc_xbar_pkg::*;
#(
    parameter int NUM_INPUTS    = 16,
    parameter int BANK_COUNT    = 32,
    parameter int TILE_SIZE     = 128,
    parameter int PRODUCT_WIDTH = 16,
    parameter int ACC_WIDTH     = 24
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [NUM_INPUTS-1:0]                              in_lane_valid,
    input  logic [NUM_INPUTS-1:0][$clog2(TILE_SIZE)-1:0]       in_row,
    input  logic [NUM_INPUTS-1:0][$clog2(TILE_SIZE)-1:0]       in_col,
    input  logic [NUM_INPUTS-1:0][PRODUCT_WIDTH-1:0]           in_value,
    input  logic                                               start_drain,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [$clog2(TILE_SIZE)-1:0]                       out_row,
    output logic [$clog2(TILE_SIZE)-1:0]                       out_col,
    output logic signed [ACC_WIDTH-1:0]                        out_value,
    output logic                                               drain_done,
    output logic                                               saturated
);

    localparam int RW    = $clog2(TILE_SIZE);
    localparam int B     = $clog2(BANK_COUNT);
    localparam int DEPTH = TILE_SIZE * TILE_SIZE / BANK_COUNT;
    localparam int EW    = $clog2(DEPTH);
    localparam int NW    = 2 * RW;

    state_t state, state_nxt;
    logic [EW-1:0]                          clr_cnt;
    logic [NUM_INPUTS-1:0]                  pending, grant;
    logic [NUM_INPUTS-1:0][RW-1:0]          lane_row_q, lane_col_q;
    logic [NUM_INPUTS-1:0][PRODUCT_WIDTH-1:0] lane_val_q;
    logic [B-1:0]                           lane_bank [NUM_INPUTS];
    logic [EW-1:0]                          lane_entry [NUM_INPUTS];
    logic [BANK_COUNT-1:0]                  acc_en, wz_en, sat_hit, busy;
    logic [EW-1:0]                          acc_addr [BANK_COUNT];
    logic signed [PRODUCT_WIDTH-1:0]        acc_prod [BANK_COUNT];
    logic signed [ACC_WIDTH-1:0]            rd_data [BANK_COUNT];
    logic [EW-1:0]                          wz_addr, rd_addr;
    logic                                   in_fire, out_fire, out_free, capture, issue;
    logic [NW-1:0]                          drain_idx;
    logic                                   drain_issued_all;
    logic [RW-1:0]                          d_row, d_col;
    logic [B-1:0]                           d_bank;
    logic                                   drain_vld_p1;
    logic [RW-1:0]                          drain_row_p1, drain_col_p1;
    logic [B-1:0]                           drain_bank_p1;
    logic [EW-1:0]                          drain_entry_p1;

    // Each bank takes the lowest-index pending lane that maps to it
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            lane_bank[i]  = B'(bank_of(int'(lane_row_q[i]), int'(lane_col_q[i]), BANK_COUNT));
            lane_entry[i] = EW'(entry_of(int'(lane_row_q[i]), int'(lane_col_q[i]),
                                         TILE_SIZE, BANK_COUNT));
        end
        for (int b = 0; b < BANK_COUNT; b++) begin
            acc_en[b]   = 1'b0;
            acc_addr[b] = '0;
            acc_prod[b] = '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (!acc_en[b] && pending[i] && lane_bank[i] == B'(b)) begin
                    acc_en[b]   = 1'b1;
                    grant[i]    = 1'b1;
                    acc_addr[b] = lane_entry[i];
                    acc_prod[b] = $signed(lane_val_q[i]);
                end
            end
        end
    end

    assign in_ready = (state == ACCUM) && ((pending & ~grant) == '0);
    assign in_fire  = in_valid && in_ready;

    assign d_row    = drain_idx[NW-1:RW];
    assign d_col    = drain_idx[RW-1:0];
    assign d_bank   = B'(bank_of(int'(d_row), int'(d_col), BANK_COUNT));
    assign rd_addr  = EW'(entry_of(int'(d_row), int'(d_col), TILE_SIZE, BANK_COUNT));
    assign out_fire = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;
    assign capture  = drain_vld_p1 && out_free;
    assign issue    = (state == DRAIN) && !drain_issued_all && (!drain_vld_p1 || out_free);
    assign drain_done = out_fire && out_row == RW'(TILE_SIZE - 1) && out_col == RW'(TILE_SIZE - 1);
    assign wz_addr  = (state == CLEAR) ? clr_cnt : drain_entry_p1;

    always_comb begin
        for (int b = 0; b < BANK_COUNT; b++)
            wz_en[b] = (state == CLEAR) || (capture && drain_bank_p1 == B'(b));
    end

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        acc_bank #(
            .DEPTH        (DEPTH),
            .AW           (EW),
            .PRODUCT_WIDTH(PRODUCT_WIDTH),
            .ACC_WIDTH    (ACC_WIDTH)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .acc_en  (acc_en[b]),
            .acc_addr(acc_addr[b]),
            .acc_prod(acc_prod[b]),
            .wz_en   (wz_en[b]),
            .wz_addr (wz_addr),
            .rd_en   (issue),
            .rd_addr (rd_addr),
            .rd_data (rd_data[b]),
            .sat_hit (sat_hit[b]),
            .busy    (busy[b])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == EW'(DEPTH - 1)) state_nxt = ACCUM;
            ACCUM:   if (start_drain) state_nxt = FLUSH;
            FLUSH:   if (pending == '0 && busy == '0) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = ACCUM;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= CLEAR;
            clr_cnt          <= '0;
            pending          <= '0;
            drain_idx        <= '0;
            drain_issued_all <= 1'b0;
            drain_vld_p1     <= 1'b0;
            out_valid        <= 1'b0;
            saturated        <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
            pending <= in_fire ? in_lane_valid : (pending & ~grant);
            if (state != DRAIN) begin
                drain_idx        <= '0;
                drain_issued_all <= 1'b0;
            end else if (issue) begin
                drain_idx <= drain_idx + 1'b1;
                if (drain_idx == '1) drain_issued_all <= 1'b1;
            end
            if (issue)        drain_vld_p1 <= 1'b1;
            else if (capture) drain_vld_p1 <= 1'b0;
            if (capture)       out_valid <= 1'b1;
            else if (out_fire) out_valid <= 1'b0;
            if (drain_done)    saturated <= 1'b0;
            else if (|sat_hit) saturated <= 1'b1;
        end
    end

    // Drain p1: bank read data lands; output register is the skid stage
    always_ff @(posedge clk) begin
        if (in_fire) begin
            lane_row_q <= in_row;
            lane_col_q <= in_col;
            lane_val_q <= in_value;
        end
        if (issue) begin
            drain_row_p1   <= d_row;
            drain_col_p1   <= d_col;
            drain_bank_p1  <= d_bank;
            drain_entry_p1 <= rd_addr;
        end
        if (capture) begin
            out_row   <= drain_row_p1;
            out_col   <= drain_col_p1;
            out_value <= rd_data[drain_bank_p1];
        end
    end

endmodule

// File: doc/accumulator_xbar_banks.md
Name: accumulator_xbar_banks

Overview:
- Parametrised successor to the current crossbar + accumulator_banks pairing for the sparse-CNN tile.
- Accepts up to NUM_INPUTS partial products per cycle, each tagged with an output (row, column).
- Routes products through a conflict-arbitrating crossbar into BANK_COUNT single-port accumulator banks and performs saturating read-modify-write accumulation.
- Streams the finished tile out in row-major order on a valid/ready drain port, clearing storage as it goes.

Parameters:
- NUM_INPUTS, 16, product lanes per input group.
- BANK_COUNT, 32, accumulator banks; power of two, BANK_COUNT <= TILE_SIZE.
- TILE_SIZE, 128, tile edge; power of two; RW = $clog2(TILE_SIZE).
- PRODUCT_WIDTH, 16, signed product width.
- ACC_WIDTH, 24, signed accumulator width; ACC_WIDTH >= PRODUCT_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input group valid.
- in_ready  out  1  group accepted when in_valid && in_ready.
- in_lane_valid  in  [NUM_INPUTS]  per-lane product present.
- in_row  in  [NUM_INPUTS][RW]  output row per lane.
- in_col  in  [NUM_INPUTS][RW]  output column per lane.
- in_value  in  [NUM_INPUTS][PRODUCT_WIDTH]  signed product per lane.
- start_drain  in  1  pulse; request tile readout.
- out_valid  out  1  drain element valid.
- out_ready  in  1  drain consumer ready.
- out_row  out  RW  drained row.
- out_col  out  RW  drained column.
- out_value  out  ACC_WIDTH  drained signed sum.
- drain_done  out  1  one-cycle pulse with the final element's handshake.
- saturated  out  1  sticky; any accumulation clipped since last drain.

Behaviour:
- Mapping (B = log2 BANK_COUNT):
  - bank = (row[B-1:0] + col[B-1:0]) mod BANK_COUNT.
  - entry = {row, col[RW-1:B]}.
  - Each bank is TILE_SIZE*TILE_SIZE/BANK_COUNT deep.
- FSM states: CLEAR, ACCUM, FLUSH, DRAIN.
- Reset:
  - State goes to CLEAR; pending mask, pipeline and skid register are cleared.
  - All outputs are 0 (in_ready=0, out_valid=0, drain_done=0, saturated=0).
  - Storage is not reset directly.
- CLEAR:
  - Writes 0 to entry k of every bank in parallel, k = 0..DEPTH-1, one entry per cycle.
  - After the last entry, go to ACCUM. in_ready=0 throughout.
- ACCUM:
  - Accepted group is latched; pending mask = in_lane_valid.
  - Each cycle, each bank grants the lowest-index pending lane targeting it.
  - Granted lanes are cleared from the pending mask.
  - in_ready = (pending & ~grant) == 0. This allows a back-to-back group in the cycle the last lanes are granted.
  - An all-zero in_lane_valid group is accepted and consumed immediately.
- Accumulation pipeline:
  - Stage 1 issues the bank read; stage 2 adds and writes.
  - The write-stage result is forwarded to a same-bank, same-entry read in the following cycle, so consecutive updates are never lost.
  - Sum is sign-extended to ACC_WIDTH+1, then saturated to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clip sets saturated.
- start_drain in ACCUM:
  - Go to FLUSH; in_ready=0 from the next cycle.
  - A group handshaking in the same cycle is still accepted and completed.
  - start_drain outside ACCUM is ignored.
- FLUSH: wait until pending mask empty and pipeline idle, then go to DRAIN.
- DRAIN:
  - Visits (row, col) row-major, (0,0)..(TILE_SIZE-1, TILE_SIZE-1).
  - Reads the mapped bank/entry and writes 0 back once the element is captured into the output skid register.
  - Output is held stable while out_valid && !out_ready.
  - Throughput is 1 element/cycle with out_ready=1.
  - First out_valid is 2 cycles after entering DRAIN.
- Drain completion:
  - drain_done pulses on the handshake of (TILE_SIZE-1, TILE_SIZE-1).
  - saturated clears in the same cycle.
  - State returns to ACCUM.
- Reset mid-operation (any state): abandon in-flight work and restart CLEAR.
  - No partial outputs after reset.
  - No drain_done for the aborted drain.

Decomposition:
- Package acc_xbar_pkg:
  - state enum (CLEAR, ACCUM, FLUSH, DRAIN).
  - Functions bank_of(row,col) and entry_of(row,col).
  - Saturating-add function sat_add(acc, prod).
- Sub-module acc_bank (one per bank):
  - Single-port storage, 2-stage RMW, forwarding, clear/drain-read port.
  - Instantiated BANK_COUNT times by generate.
- Crossbar arbitration and FSM stay in the top.

Test Plan:
(All with NUM_INPUTS=4, BANK_COUNT=4, TILE_SIZE=8, ACC_WIDTH=24 unless noted.)
- Reset held 2 cycles -> in_ready=0 for exactly 16 cycles after release, then 1; drain yields 64 zeros.
- Lanes 0-3 all (0,0), values 1,2,3,4, one group -> in_ready low for 3 cycles; drain gives (0,0)=10, all others 0.
- Lanes to (0,0),(0,1),(0,2),(0,3) (distinct banks), values 5,6,7,8 -> in_ready stays 1 and the next group is accepted the following cycle; drain shows 5,6,7,8.
- Single lane +5 to (3,3) for 6 back-to-back groups -> drained (3,3)=30 (forwarding check).
- ACC_WIDTH=8: +100 then +100 to (1,2) -> drained 127, saturated=1 until drain_done; -100 three times to (2,2) -> -128.
- Drain with out_ready toggled pseudo-randomly -> 64 outputs in row-major order, no duplicates or stalls-corrupted data, drain_done once; a second drain returns all zeros. Reset asserted at element 20 of a drain -> out_valid=0 next cycle, CLEAR runs 16 cycles, a later drain returns all zeros.
